// File: rtl/cdb_arbiter_pkg.sv
// Shared core types for the common-data-bus: widths and the result entry carried to wakeup consumers.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cdb_arbiter_pkg;

  localparam int CDB_TAG_W  = 6;
  localparam int CDB_ROB_W  = 6;
  localparam int CDB_DATA_W = 32;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] value;
    logic [CDB_ROB_W-1:0]  rob_index;
  } cdb_entry_t;

  localparam int CDB_ENTRY_W = $bits(cdb_entry_t);

endpackage

// File: rtl/cdb_req_fifo.sv
// Per-requester result FIFO (DEPTH entries, power of 2) with occupancy count and synchronous flush.
// Latency: a pushed entry becomes the head at the next edge; no write-to-head bypass.
// Backpressure: full is derived from the registered count only; pushes while full are ignored.
module cdb_req_fifo #(
  parameter int W     = 44,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of 2, so pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-requester FIFOs, up to N_BUS round-robin grants per cycle onto registered wakeup buses; CDB_STALL_CNT_EN adds stall counters.
// Latency: an entry pushed at edge E0 is broadcast no earlier than edge E0+1, visible for exactly one cycle.
// Backpressure: req_ready[i] is FIFO i not full (registered count only); an unaccepted offer must be held.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int N_BUS  = 2,
  parameter int DEPTH  = 2,
  parameter int TAG_W  = CDB_TAG_W,
  parameter int ROB_W  = CDB_ROB_W,
  parameter int DATA_W = CDB_DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_value,
  input  logic [N_REQ*ROB_W-1:0]  req_rob_index,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_BUS-1:0]        bus_valid,
  output logic [N_BUS*TAG_W-1:0]  bus_tag,
  output logic [N_BUS*DATA_W-1:0] bus_value,
  output logic [N_BUS*ROB_W-1:0]  bus_rob_index
`ifdef CDB_STALL_CNT_EN
  ,
  output logic [N_REQ*16-1:0]     stall_count
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  cdb_entry_t       heads [N_REQ];
  logic [N_REQ-1:0] fifo_empty;
  logic [N_REQ-1:0] fifo_full;
  logic [N_REQ-1:0] grant;
  logic [N_BUS-1:0] slot_vld;
  logic [PTR_W-1:0] slot_src [N_BUS];
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] next_ptr;

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    cdb_entry_t in_entry;

    assign in_entry = '{tag:       req_tag[i*TAG_W +: TAG_W],
                        value:     req_value[i*DATA_W +: DATA_W],
                        rob_index: req_rob_index[i*ROB_W +: ROB_W]};

    cdb_req_fifo #(
      .W     (CDB_ENTRY_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .push      (req_valid[i]),
      .push_data (in_entry),
      .pop       (grant[i]),
      .head      (heads[i]),
      .empty     (fifo_empty[i]),
      .full      (fifo_full[i])
    );

    assign req_ready[i] = ~fifo_full[i];
  end

  // Scan from rr_ptr, wrapping; the j-th non-empty head found drives slot j.
  always_comb begin
    int found;
    int idx;
    grant    = '0;
    slot_vld = '0;
    next_ptr = rr_ptr;
    found    = 0;
    idx      = 0;
    for (int k = 0; k < N_BUS; k++) slot_src[k] = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!fifo_empty[idx] && found < N_BUS) begin
        grant[idx]      = 1'b1;
        slot_vld[found] = 1'b1;
        slot_src[found] = PTR_W'(idx);
        next_ptr        = PTR_W'((idx + 1) % N_REQ);
        found           = found + 1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr        <= '0;
      bus_valid     <= '0;
      bus_tag       <= '0;
      bus_value     <= '0;
      bus_rob_index <= '0;
    end else if (flush) begin
      rr_ptr        <= '0;
      bus_valid     <= '0;
      bus_tag       <= '0;
      bus_value     <= '0;
      bus_rob_index <= '0;
    end else begin
      rr_ptr <= next_ptr;
      for (int k = 0; k < N_BUS; k++) begin
        bus_valid[k] <= slot_vld[k];
        if (slot_vld[k]) begin
          bus_tag[k*TAG_W +: TAG_W]       <= heads[slot_src[k]].tag;
          bus_value[k*DATA_W +: DATA_W]   <= heads[slot_src[k]].value;
          bus_rob_index[k*ROB_W +: ROB_W] <= heads[slot_src[k]].rob_index;
        end else begin
          bus_tag[k*TAG_W +: TAG_W]       <= '0;
          bus_value[k*DATA_W +: DATA_W]   <= '0;
          bus_rob_index[k*ROB_W +: ROB_W] <= '0;
        end
      end
    end
  end

`ifdef CDB_STALL_CNT_EN
  // Survives flush on purpose: the counters profile the whole run, not one speculation window.
  logic [15:0] stall_q [N_REQ];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) stall_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!fifo_empty[i] && !grant[i] && stall_q[i] != 16'hFFFF)
          stall_q[i] <= stall_q[i] + 16'd1;
      end
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_stall
    assign stall_count[i*16 +: 16] = stall_q[i];
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a cycle-by-cycle vector table plus hand-written reset sequences.
// Default parameters (N_REQ=4, N_BUS=2, DEPTH=2).
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic [3:0]   req_valid;
  logic [23:0]  req_tag;
  logic [127:0] req_value;
  logic [23:0]  req_rob_index;
  logic [3:0]   req_ready;
  logic [1:0]   bus_valid;
  logic [11:0]  bus_tag;
  logic [63:0]  bus_value;
  logic [11:0]  bus_rob_index;
`ifdef CDB_STALL_CNT_EN
  logic [63:0]  stall_count;
`endif

  int checks = 0;
  int errors = 0;

  cdb_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .req_valid     (req_valid),
    .req_tag       (req_tag),
    .req_value     (req_value),
    .req_rob_index (req_rob_index),
    .req_ready     (req_ready),
    .bus_valid     (bus_valid),
    .bus_tag       (bus_tag),
    .bus_value     (bus_value),
    .bus_rob_index (bus_rob_index)
`ifdef CDB_STALL_CNT_EN
    ,
    .stall_count   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic [3:0]  vld;
    logic [23:0] tags;
    logic [1:0]  exp_bv;
    logic [5:0]  exp_t0;
    logic [5:0]  exp_t1;
    logic [3:0]  exp_rdy;
  } vec_t;

  vec_t vecs[$];

  // Tag 5 maps to value DEADBEEF and ROB index 3.
  function automatic logic [31:0] val_of(logic [5:0] t);
    return 32'hDEADBEEF + {26'd0, t} - 32'd5;
  endfunction

  function automatic logic [5:0] rob_of(logic [5:0] t);
    return t ^ 6'h06;
  endfunction

  function automatic vec_t mk(logic fl, logic [3:0] vld,
                              logic [5:0] t3, logic [5:0] t2, logic [5:0] t1, logic [5:0] t0,
                              logic [1:0] bv, logic [5:0] e0, logic [5:0] e1, logic [3:0] rdy);
    vec_t v;
    v.fl = fl; v.vld = vld; v.tags = {t3, t2, t1, t0};
    v.exp_bv = bv; v.exp_t0 = e0; v.exp_t1 = e1; v.exp_rdy = rdy;
    return v;
  endfunction

  task automatic drive(logic fl, logic [3:0] vld, logic [23:0] tags);
    flush     = fl;
    req_valid = vld;
    req_tag   = tags;
    for (int i = 0; i < 4; i++) begin
      req_value[i*32 +: 32]    = val_of(tags[i*6 +: 6]);
      req_rob_index[i*6 +: 6]  = rob_of(tags[i*6 +: 6]);
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bus(string nm, logic [1:0] bv, logic [5:0] t0, logic [5:0] t1, logic [3:0] rdy);
    logic [5:0] et [2];
    et[0] = t0;
    et[1] = t1;
    check({nm, " bus_valid"}, 32'(bus_valid), 32'(bv));
    check({nm, " req_ready"}, 32'(req_ready), 32'(rdy));
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s slot%0d tag", nm, k), 32'(bus_tag[k*6 +: 6]),
            bv[k] ? 32'(et[k]) : 32'd0);
      check($sformatf("%s slot%0d value", nm, k), bus_value[k*32 +: 32],
            bv[k] ? val_of(et[k]) : 32'd0);
      check($sformatf("%s slot%0d rob", nm, k), 32'(bus_rob_index[k*6 +: 6]),
            bv[k] ? 32'(rob_of(et[k])) : 32'd0);
    end
  endtask

  initial begin
    // Single result, then flush (rr_ptr back to 0), then the four-way burst.
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 5,     2'b00, 0, 0, 4'hF));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0,     2'b01, 5, 0, 4'hF));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0,     2'b00, 0, 0, 4'hF));
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0,     2'b00, 0, 0, 4'hF));
    vecs.push_back(mk(0, 4'b1111, 4, 3, 2, 1,     2'b00, 0, 0, 4'hF));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0,     2'b11, 1, 2, 4'hF));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0,     2'b11, 3, 4, 4'hF));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0,     2'b00, 0, 0, 4'hF));
    // rr_ptr must be 0 here: requester 0 beats requester 3 for slot 0.
    vecs.push_back(mk(0, 4'b1001, 9, 0, 0, 8,     2'b00, 0, 0, 4'hF));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0,     2'b11, 8, 9, 4'hF));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0,     2'b00, 0, 0, 4'hF));
    // Backpressure: all four push every cycle; FIFOs fill, held offers land later, order kept.
    vecs.push_back(mk(0, 4'b1111, 13, 12, 11, 10, 2'b00, 0, 0, 4'hF));
    vecs.push_back(mk(0, 4'b1111, 23, 22, 21, 20, 2'b11, 10, 11, 4'b0011));
    vecs.push_back(mk(0, 4'b1111, 33, 32, 31, 30, 2'b11, 12, 13, 4'b1100));
    vecs.push_back(mk(0, 4'b1100, 33, 32, 31, 30, 2'b11, 20, 21, 4'b0011));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0,     2'b11, 22, 23, 4'hF));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0,     2'b11, 30, 31, 4'hF));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0,     2'b11, 32, 33, 4'hF));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0,     2'b00, 0, 0, 4'hF));
    // Flush with rr_ptr=1 and three entries buffered plus a push offered in the flush cycle.
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 39,    2'b00, 0, 0, 4'hF));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0,     2'b01, 39, 0, 4'hF));
    vecs.push_back(mk(0, 4'b1110, 43, 42, 41, 0,  2'b00, 0, 0, 4'hF));
    vecs.push_back(mk(1, 4'b0100, 0, 46, 0, 0,    2'b00, 0, 0, 4'hF));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0,     2'b00, 0, 0, 4'hF));
    // Tag 0 is broadcast normally; order 0 before 3 proves rr_ptr cleared by flush.
    vecs.push_back(mk(0, 4'b1001, 44, 0, 0, 0,    2'b00, 0, 0, 4'hF));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0,     2'b11, 0, 44, 4'hF));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0,     2'b00, 0, 0, 4'hF));

    reset = 1'b1;
    drive(1'b0, 4'b0000, 24'd0);
    #12;
    check_bus("reset", 2'b00, 6'd0, 6'd0, 4'hF);
    #10 reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].fl, vecs[i].vld, vecs[i].tags);
      @(posedge clk);
      #1;
      check_bus($sformatf("v%0d", i), vecs[i].exp_bv, vecs[i].exp_t0, vecs[i].exp_t1, vecs[i].exp_rdy);
    end

    // Reset mid-stream while both slots are broadcasting.
    drive(1'b0, 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1});
    @(posedge clk);
    #1;
    drive(1'b0, 4'b0000, 24'd0);
    @(posedge clk);
    #1;
    check_bus("pre_reset", 2'b11, 6'd1, 6'd2, 4'hF);
    #2 reset = 1'b1;
    #1;
    check_bus("async_reset", 2'b00, 6'd0, 6'd0, 4'hF);
    @(posedge clk);
    #3 reset = 1'b0;
    drive(1'b0, 4'b0100, {6'd0, 6'd7, 6'd0, 6'd0});
    @(posedge clk);
    #1;
    check_bus("post_reset_push", 2'b00, 6'd0, 6'd0, 4'hF);
    drive(1'b0, 4'b0000, 24'd0);
    @(posedge clk);
    #1;
    check_bus("post_reset_bcast", 2'b01, 6'd7, 6'd0, 4'hF);
    @(posedge clk);
    #1;
    check_bus("post_reset_drain", 2'b00, 6'd0, 6'd0, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
